pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, giving the width of the packed stage payload (operands, immediate, compare result).
REQ-002 The block SHALL have parameter A3_W, default 5, giving the width of the destination register index.
REQ-003 The block SHALL have parameter RESET_PC, default 32'h00003000, giving the PC presented for a bubble.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the width of the bubble counter.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port flush, input, 1 bit, synchronous kill of all held and incoming entries.
REQ-008 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-009 The block SHALL have ports in_data (input, DATA_W), in_pc (input, 32) and in_a3 (input, A3_W), the upstream payload.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-011 The block SHALL have ports out_data (output, DATA_W), out_pc (output, 32) and out_a3 (output, A3_W), the registered payload.
REQ-012 The block SHALL have port bubble_cnt, output, CNT_W bits, a saturating count of cycles with out_valid=0.

Function
REQ-013 Storage SHALL be two entries: main (drives outputs) and skid (overflow); each entry holds a valid bit, data, pc and a3.
REQ-014 in_ready SHALL equal NOT skid.valid, registered, with no combinational path from out_ready.
REQ-015 An upstream transfer SHALL occur when in_valid and in_ready are both 1 at a rising edge; a downstream transfer when out_valid and out_ready are both 1.
REQ-016 out_valid SHALL equal main.valid; when main.valid=0, outputs SHALL be out_data=0, out_pc=RESET_PC, out_a3=0 (bubble).
REQ-017 When main is empty or transfers downstream, main SHALL load skid if skid.valid, else the accepted input, else become empty.
REQ-018 An accepted input SHALL go to skid when main is valid and does not transfer downstream, or when main loads from skid in that cycle.
REQ-019 Entries SHALL leave in acceptance order; no entry SHALL be dropped or duplicated while flush=0.
REQ-020 Latency SHALL be one cycle (accepted at edge N, out_valid at N) when main is empty or draining; throughput SHALL be one entry per cycle with out_ready held 1.
REQ-021 flush=1 SHALL clear main.valid and skid.valid at the edge, discard any input offered that cycle, and override all other updates.
REQ-022 After a flush edge, outputs SHALL show bubble values and in_ready SHALL be 1.
REQ-023 out_valid=1 with out_ready=0 SHALL hold out_data, out_pc and out_a3 stable until the transfer.
REQ-024 bubble_cnt SHALL increment at every edge where out_valid=0, saturate at 2^CNT_W-1, and never wrap.
REQ-025 Skid full (in_ready=0) with in_valid=1 SHALL leave all state unchanged except downstream draining.

Reset
REQ-026 reset=1 SHALL asynchronously clear main.valid and skid.valid, set out_data=0, out_pc=RESET_PC, out_a3=0, in_ready=1 and bubble_cnt=0, independent of clk.
REQ-027 A reset asserted mid-transfer SHALL discard both entries; the first edge after deassertion SHALL behave as an empty stage.
REQ-028 Power-up simulation values SHALL match the reset values.

Verification
REQ-029 Stream: in_data=1..8, pc=0x3000+4k, out_ready=1 -> out_data 1..8 on consecutive cycles, one cycle after each accept; in_ready always 1.
REQ-030 Backpressure: out_ready=0 after two accepts (A, B) -> out shows A, in_ready=0; out_ready=1 -> A, B emitted in order; in_ready returns to 1.
REQ-031 Flush: A in main, B in skid, C offered, flush=1 -> next cycle out_valid=0, out_pc=0x3000, out_a3=0, in_ready=1; A, B, C never appear.
REQ-032 Async reset: pulse reset between edges with both entries valid -> out_valid=0 and bubble_cnt=0 immediately, without a clock edge.
REQ-033 Saturation: CNT_W=4, idle 20 cycles -> bubble_cnt reaches 15 and holds.
REQ-034 Simultaneous events: flush=1 and out_ready=1 with main valid -> the main entry counts as flushed; no further valid output follows.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register: a main entry drives the outputs and a skid entry absorbs
// one upstream transfer so that in_ready depends only on stored state, never on out_ready.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned A3_W     = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic [A3_W-1:0]   in_a3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [A3_W-1:0]   out_a3,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [31:0]       main_pc;
    logic [A3_W-1:0]   main_a3;

    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [31:0]       skid_pc;
    logic [A3_W-1:0]   skid_a3;

    logic up_xfer;
    logic dn_xfer;
    logic main_free;

    assign in_ready  = ~skid_valid;
    assign up_xfer   = in_valid & in_ready;
    assign dn_xfer   = main_valid & out_ready;
    assign main_free = ~main_valid | dn_xfer;

    // Payload is forced to bubble values whenever main is empty.
    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_data : '0;
    assign out_pc    = main_valid ? main_pc   : RESET_PC;
    assign out_a3    = main_valid ? main_a3   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_pc    <= RESET_PC;
            main_a3    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_pc    <= RESET_PC;
            skid_a3    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_pc    <= skid_pc;
                main_a3    <= skid_a3;
                skid_valid <= up_xfer;
                if (up_xfer) begin
                    skid_data <= in_data;
                    skid_pc   <= in_pc;
                    skid_a3   <= in_a3;
                end
            end else if (up_xfer) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
                main_pc    <= in_pc;
                main_a3    <= in_a3;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (up_xfer) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            skid_pc    <= in_pc;
            skid_a3    <= in_a3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!main_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: streaming, backpressure, flush, async reset, counter saturation.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic [31:0]  in_pc = '0;
    logic [4:0]   in_a3 = '0;
    logic         out_ready = 1'b0;

    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic [31:0]  out_pc;
    logic [4:0]   out_a3;
    logic [15:0]  bubble_cnt;

    logic         s_in_ready;
    logic         s_out_valid;
    logic [127:0] s_out_data;
    logic [31:0]  s_out_pc;
    logic [4:0]   s_out_a3;
    logic [3:0]   s_bubble_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_pc(in_pc), .in_a3(in_a3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_pc(out_pc), .out_a3(out_a3),
        .bubble_cnt(bubble_cnt)
    );

    // Idle instance: never fed, so its narrow counter only counts bubbles.
    pipe_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(1'b0), .in_ready(s_in_ready),
        .in_data('0), .in_pc('0), .in_a3('0),
        .out_valid(s_out_valid), .out_ready(1'b1),
        .out_data(s_out_data), .out_pc(s_out_pc), .out_a3(s_out_a3),
        .bubble_cnt(s_bubble_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [127:0] d, input logic [31:0] pc, input logic [4:0] a3);
        in_valid = 1'b1;
        in_data  = d;
        in_pc    = pc;
        in_a3    = a3;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk({tag, "_data"}, out_data, '0);
        chk({tag, "_pc"}, out_pc, 32'h3000);
        chk({tag, "_a3"}, out_a3, 5'd0);
    endtask

    initial begin
        #1;
        chk_bubble("rst");
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_bcnt", bubble_cnt, 16'd0);
        step();
        step();
        reset = 1'b0;

        // three idle edges -> bubble_cnt 3
        repeat (3) step();
        chk("idle_bcnt", bubble_cnt, 16'd3);
        chk("idle_sat_bcnt", s_bubble_cnt, 4'd3);

        // stream 1..8 with out_ready held high
        out_ready = 1'b1;
        for (int unsigned k = 1; k <= 8; k++) begin
            offer(128'(k), 32'h3000 + 32'(4 * k), 5'(k));
            step();
            chk("strm_valid", out_valid, 1'b1);
            chk("strm_data", out_data, 128'(k));
            chk("strm_pc", out_pc, 32'h3000 + 32'(4 * k));
            chk("strm_a3", out_a3, 5'(k));
            chk("strm_in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        step();
        chk_bubble("strm_end");
        chk("strm_bcnt", bubble_cnt, 16'd4);

        // backpressure: A then B held, C offered while full
        out_ready = 1'b0;
        offer(128'hA, 32'h3100, 5'd3);
        step();
        chk("bp_a_data", out_data, 128'hA);
        chk("bp_a_in_ready", in_ready, 1'b1);
        offer(128'hB, 32'h3104, 5'd4);
        step();
        chk("bp_hold_data", out_data, 128'hA);
        chk("bp_hold_pc", out_pc, 32'h3100);
        chk("bp_full_in_ready", in_ready, 1'b0);
        offer(128'hC, 32'h3108, 5'd5);
        step();
        chk("bp_full2_data", out_data, 128'hA);
        chk("bp_full2_a3", out_a3, 5'd3);
        chk("bp_full2_in_ready", in_ready, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_b_valid", out_valid, 1'b1);
        chk("bp_b_data", out_data, 128'hB);
        chk("bp_b_pc", out_pc, 32'h3104);
        chk("bp_b_in_ready", in_ready, 1'b1);
        step();
        chk_bubble("bp_end");
        chk("bp_bcnt", bubble_cnt, 16'd5);

        // flush with A in main, B in skid, C offered
        out_ready = 1'b0;
        offer(128'hA, 32'h3200, 5'd1);
        step();
        offer(128'hB, 32'h3204, 5'd2);
        step();
        chk("fl_full_in_ready", in_ready, 1'b0);
        offer(128'hC, 32'h3208, 5'd3);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_bubble("fl");
        chk("fl_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        step();
        chk("fl_after1_valid", out_valid, 1'b0);
        step();
        chk("fl_after2_valid", out_valid, 1'b0);

        // flush discards an input accepted in the same cycle
        out_ready = 1'b0;
        offer(128'hD, 32'h3300, 5'd6);
        step();
        offer(128'hE, 32'h3304, 5'd7);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_bubble("fl_in");
        out_ready = 1'b1;
        step();
        chk("fl_in_after_valid", out_valid, 1'b0);

        // flush and downstream transfer coincide
        offer(128'hF, 32'h3400, 5'd8);
        step();
        chk("fl_dn_pre_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk_bubble("fl_dn");
        step();
        chk("fl_dn_after_valid", out_valid, 1'b0);

        // async reset between edges with both entries valid
        out_ready = 1'b0;
        offer(128'h11, 32'h3500, 5'd9);
        step();
        offer(128'h22, 32'h3504, 5'd10);
        step();
        in_valid = 1'b0;
        chk("ar_pre_in_ready", in_ready, 1'b0);
        chk("ar_pre_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_bubble("ar");
        chk("ar_bcnt", bubble_cnt, 16'd0);
        chk("ar_in_ready", in_ready, 1'b1);
        chk("ar_sat_bcnt", s_bubble_cnt, 4'd0);
        #1 reset = 1'b0;

        // first edge after reset behaves as an empty stage
        offer(128'h33, 32'h3600, 5'd11);
        step();
        chk("ar_post_valid", out_valid, 1'b1);
        chk("ar_post_data", out_data, 128'h33);
        chk("ar_post_bcnt", bubble_cnt, 16'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("ar_post_drain", out_valid, 1'b0);

        // saturation of the 4-bit counter
        repeat (20) step();
        chk("sat_bcnt", s_bubble_cnt, 4'd15);
        chk("wide_bcnt", bubble_cnt, 16'd21);
        repeat (5) step();
        chk("sat_hold_bcnt", s_bubble_cnt, 4'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end

endmodule
